// File: rtl/hud_digit_updater.sv
// HUD digit sequencer: clears the 14-blob digit bank, then serves score/combo/hits
// updates round-robin through a serial double-dabble. Optional macro: HUD_LZ_BLANK_EN.
module hud_digit_updater #(
  parameter int SCORE_BASE = 0,
  parameter int COMBO_BASE = 6,
  parameter int HITS_BASE  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [19:0] score_val,
  input  logic [13:0] combo_val,
  input  logic [13:0] hits_val,
  output logic [2:0]  ack,
  output logic        busy,
  output logic        write,
  output logic [3:0]  num,
  output logic [3:0]  blob,
  output logic [1:0]  state_dbg
);

  // Handshake: each req bit is a level held until its one-cycle ack pulse; a
  // requester whose ack is high this cycle is masked out of arbitration.
  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_CONV  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t      state;
  logic [1:0]  rr;
  logic [1:0]  g;
  logic [4:0]  cnt;
  logic [43:0] shreg;

  logic [2:0]  masked;
  logic [1:0]  pick;
  logic [19:0] sat_val;
  logic [4:0]  n_dig;
  logic [3:0]  base;
  logic [23:0] bcd;
  logic [2:0]  dsel;
  logic [3:0]  digit;
  logic [3:0]  out_digit;
  logic [3:0]  init_num;
  logic        write_slot;

  assign state_dbg = state;

  function automatic logic [1:0] rr_pick(input logic [2:0] m, input logic [1:0] p);
    logic [1:0] sel;
    logic [2:0] s;
    sel = 2'd0;
    // Walk from the farthest offset down so the nearest pending requester wins.
    for (int i = 2; i >= 0; i--) begin
      s = {1'b0, p} + 3'(i);
      if (s >= 3'd3) s = s - 3'd3;
      if (m[s[1:0]]) sel = s[1:0];
    end
    return sel;
  endfunction

  function automatic logic [43:0] dabble_step(input logic [43:0] x);
    logic [43:0] y;
    y = x;
    for (int i = 0; i < 6; i++) begin
      if (y[20+4*i +: 4] >= 4'd5) y[20+4*i +: 4] = y[20+4*i +: 4] + 4'd3;
    end
    return {y[42:0], 1'b0};
  endfunction

  always_comb begin
    masked = req & ~ack;
    pick   = rr_pick(masked, rr);
    case (pick)
      2'd0:    sat_val = (score_val > 20'd999999) ? 20'd999999 : score_val;
      2'd1:    sat_val = (combo_val > 14'd9999) ? 20'd9999 : {6'd0, combo_val};
      default: sat_val = (hits_val > 14'd9999) ? 20'd9999 : {6'd0, hits_val};
    endcase
  end

  always_comb begin
    n_dig = (g == 2'd0) ? 5'd6 : 5'd4;
    case (g)
      2'd0:    base = 4'(SCORE_BASE);
      2'd1:    base = 4'(COMBO_BASE);
      default: base = 4'(HITS_BASE);
    endcase
    bcd        = shreg[43:20];
    dsel       = 3'(n_dig - 5'd1 - cnt);
    digit      = 4'(bcd >> {dsel, 2'b00});
    write_slot = (cnt != n_dig);
  end

`ifdef HUD_LZ_BLANK_EN
  logic lead;

  // The last digit of a field is always shown so zero renders as "0".
  always_comb begin
    out_digit = (lead && digit == 4'd0 && cnt != n_dig - 5'd1) ? 4'hF : digit;
    init_num  = (cnt == 5'd13) ? 4'd0 : 4'hF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lead <= 1'b1;
    end else if (state == S_CONV) begin
      lead <= 1'b1;
    end else if (state == S_WRITE && write_slot) begin
      lead <= lead && (digit == 4'd0);
    end
  end
`else
  always_comb begin
    out_digit = digit;
    init_num  = 4'd0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
      rr    <= 2'd0;
      g     <= 2'd0;
      cnt   <= 5'd0;
      shreg <= 44'd0;
      write <= 1'b0;
      num   <= 4'd0;
      blob  <= 4'd0;
      ack   <= 3'b000;
      busy  <= 1'b1;
    end else begin
      ack   <= 3'b000;
      write <= 1'b0;
      case (state)
        S_INIT: begin
          if (cnt == 5'd14) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= 5'd0;
          end else begin
            write <= 1'b1;
            blob  <= cnt[3:0];
            num   <= init_num;
            cnt   <= cnt + 5'd1;
          end
        end
        S_IDLE: begin
          if (|masked) begin
            g     <= pick;
            rr    <= (pick == 2'd2) ? 2'd0 : pick + 2'd1;
            shreg <= {24'd0, sat_val};
            cnt   <= 5'd0;
            busy  <= 1'b1;
            state <= S_CONV;
          end
        end
        S_CONV: begin
          shreg <= dabble_step(shreg);
          if (cnt == 5'd19) begin
            cnt   <= 5'd0;
            state <= S_WRITE;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        S_WRITE: begin
          // One extra pass after the last digit drops write and raises ack together.
          if (!write_slot) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            ack   <= 3'b001 << g;
            cnt   <= 5'd0;
          end else begin
            write <= 1'b1;
            blob  <= base + cnt[3:0];
            num   <= out_digit;
            cnt   <= cnt + 5'd1;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_hud_digit_updater.sv
// Directed bench for hud_digit_updater: write scoreboard, ack/latency checks,
// round-robin order and mid-update reset.
module tb_hud_digit_updater;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [19:0] score_val = 20'd0;
  logic [13:0] combo_val = 14'd0;
  logic [13:0] hits_val = 14'd0;
  logic [2:0]  ack;
  logic        busy;
  logic        write;
  logic [3:0]  num;
  logic [3:0]  blob;
  logic [1:0]  state_dbg;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [7:0]  exp_q[$];
  int          ack_order[$];
  int          ack_cnt[3] = '{default: 0};
  int          wr_total = 0;
  int          first_wr_cyc = 0;
  logic        write_d = 1'b0;
  logic [7:0]  mon_e;

  hud_digit_updater dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .score_val (score_val),
    .combo_val (combo_val),
    .hits_val  (hits_val),
    .ack       (ack),
    .busy      (busy),
    .write     (write),
    .num       (num),
    .blob      (blob),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Scoreboard: every write is matched in order against exp_q
  always @(negedge clk) begin
    if (write) begin
      if (!write_d) first_wr_cyc = cyc;
      wr_total++;
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_blob_num", {24'd0, blob, num}, {24'd0, mon_e});
      end
    end
    write_d = write;
    for (int b = 0; b < 3; b++) begin
      if (ack[b]) begin
        ack_cnt[b]++;
        ack_order.push_back(b);
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_field(input int base, input int n, input int val);
    int d;
    int div;
`ifdef HUD_LZ_BLANK_EN
    bit lead;
    lead = 1'b1;
`endif
    div = 1;
    for (int k = 1; k < n; k++) div = div * 10;
    for (int k = 0; k < n; k++) begin
      d = (val / div) % 10;
      div = div / 10;
`ifdef HUD_LZ_BLANK_EN
      if (lead && d == 0 && k != n - 1) d = 15;
      else lead = 1'b0;
`endif
      exp_q.push_back({4'(base + k), 4'(d)});
    end
  endtask

  task automatic push_init();
    for (int k = 0; k < 14; k++) begin
`ifdef HUD_LZ_BLANK_EN
      exp_q.push_back({4'(k), (k == 13) ? 4'h0 : 4'hF});
`else
      exp_q.push_back({4'(k), 4'h0});
`endif
    end
  endtask

  task automatic wait_update(input int r, input int n);
    int c0;
    int c1;
    int w0;
    int a0;
    bit got;
    w0 = wr_total;
    a0 = ack_cnt[r];
    c0 = 0;
    c1 = 0;
    req[r] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (busy) begin
        got = 1'b1;
        c0 = cyc;
        break;
      end
    end
    check("grant_seen", 32'(got), 32'd1);
    got = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (ack[r]) begin
        got = 1'b1;
        c1 = cyc;
        break;
      end
    end
    check("ack_seen", 32'(got), 32'd1);
    check("ack_latency", c1 - c0, 21 + n);
    check("first_wr_latency", first_wr_cyc - c0, 21);
    check("busy_at_ack", 32'(busy), 32'd0);
    req[r] = 1'b0;
    step();
    step();
    check("ack_once", ack_cnt[r] - a0, 1);
    check("wr_count", wr_total - w0, n);
    check("exp_left", exp_q.size(), 0);
  endtask

  initial begin
    int  nb;
    int  w0;
    int  a0;
    int  base_ack[3];
    bit  got;
    logic [2:0] pend;

    // Reset state and INIT sweep
    repeat (3) step();
    check("rst_write", 32'(write), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_num", 32'(num), 32'd0);
    check("rst_blob", 32'(blob), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    push_init();
    w0 = wr_total;
    nb = 0;
    got = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (busy) nb++;
      else begin
        got = 1'b1;
        break;
      end
    end
    check("init_done", 32'(got), 32'd1);
    check("init_busy_cycles", nb, 14);
    check("init_writes", wr_total - w0, 14);
    check("init_exp_left", exp_q.size(), 0);
    check("init_acks", ack_cnt[0] + ack_cnt[1] + ack_cnt[2], 0);

    // All three requesters at once: score, combo, hits in turn
    score_val = 20'd42;
    combo_val = 14'd305;
    hits_val  = 14'd9999;
    push_field(0, 6, 42);
    push_field(6, 4, 305);
    push_field(10, 4, 9999);
    ack_order.delete();
    for (int b = 0; b < 3; b++) base_ack[b] = ack_cnt[b];
    req = 3'b111;
    pend = 3'b000;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      req = req & ~pend;
      pend = ack;
      if (req == 3'b000 && !busy) begin
        got = 1'b1;
        break;
      end
    end
    check("rr_done", 32'(got), 32'd1);
    check("rr_ack_events", ack_order.size(), 3);
    if (ack_order.size() >= 3) begin
      check("rr_order0", ack_order[0], 0);
      check("rr_order1", ack_order[1], 1);
      check("rr_order2", ack_order[2], 2);
    end
    for (int b = 0; b < 3; b++) check("rr_ack_once", ack_cnt[b] - base_ack[b], 1);
    repeat (3) step();
    check("rr_no_regrant", 32'(busy), 32'd0);
    check("rr_exp_left", exp_q.size(), 0);

    // Single-field updates
    score_val = 20'd123456;
    exp_q.push_back(8'h01); exp_q.push_back(8'h12); exp_q.push_back(8'h23);
    exp_q.push_back(8'h34); exp_q.push_back(8'h45); exp_q.push_back(8'h56);
    wait_update(0, 6);

    combo_val = 14'd16383;
    exp_q.push_back(8'h69); exp_q.push_back(8'h79);
    exp_q.push_back(8'h89); exp_q.push_back(8'h99);
    wait_update(1, 4);

    hits_val = 14'd7;
`ifdef HUD_LZ_BLANK_EN
    exp_q.push_back(8'hAF); exp_q.push_back(8'hBF);
    exp_q.push_back(8'hCF); exp_q.push_back(8'hD7);
`else
    exp_q.push_back(8'hA0); exp_q.push_back(8'hB0);
    exp_q.push_back(8'hC0); exp_q.push_back(8'hD7);
`endif
    wait_update(2, 4);

    score_val = 20'hFFFFF;
    push_field(0, 6, 999999);
    wait_update(0, 6);

    combo_val = 14'd0;
    push_field(6, 4, 0);
    wait_update(1, 4);

    score_val = 20'd1000;
    push_field(0, 6, 1000);
    wait_update(0, 6);

    hits_val = 14'd10000;
    push_field(10, 4, 9999);
    wait_update(2, 4);

    // Reset during the third write of a score update
    score_val = 20'd123456;
    exp_q.push_back(8'h01); exp_q.push_back(8'h12); exp_q.push_back(8'h23);
    a0 = ack_cnt[0];
    req[0] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (write && blob == 4'd2) begin
        got = 1'b1;
        break;
      end
    end
    check("mid_third_write", 32'(got), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_write", 32'(write), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd1);
    check("mid_rst_state", 32'(state_dbg), 32'd0);
    repeat (3) step();
    check("mid_exp_left", exp_q.size(), 0);
    check("mid_no_ack", ack_cnt[0] - a0, 0);
    push_init();
    push_field(0, 6, 123456);
    w0 = wr_total;
    rst_n = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 120; i++) begin
      step();
      if (ack[0]) begin
        got = 1'b1;
        break;
      end
    end
    check("mid_ack_after", 32'(got), 32'd1);
    req[0] = 1'b0;
    step();
    step();
    check("mid_writes", wr_total - w0, 20);
    check("mid_exp_done", exp_q.size(), 0);
    check("mid_ack_once", ack_cnt[0] - a0, 1);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
